// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM responder.
// A 32-bit word is moved as two 16-bit half-words.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int unsigned DEFAULT_BASE_ADDR = 1024;
  localparam int unsigned DEFAULT_SRAM_AW   = 18;
  localparam int unsigned HALF_W            = 16;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request bus between the pipeline and the SRAM responder.
interface sram_controller_if;

  // rd_en/wr_en/address/write_data are held by the master until ready=1;
  // the access retires on the edge where ready=1, and a request seen while
  // ready=0 in IDLE is the one being accepted.
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: counts 0..WAIT_CYCLES-1 and wraps to 0 after last.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

  assign last = (count == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Word load/store responder on a 16-bit asynchronous SRAM: each 32-bit
// access is two WAIT_CYCLES-long half-word phases, low half first.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned SRAM_AW     = DEFAULT_SRAM_AW
) (
  input  logic                clk,
  input  logic                rst,
  sram_controller_if.slave    mem,
  inout  wire  [HALF_W-1:0]   SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_WE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output mem_state_t          dbg_state
);

  localparam int unsigned WORD_W = SRAM_AW - 1;
  localparam bit ONE_CYCLE = (WAIT_CYCLES == 1);

  mem_state_t        state;
  logic              is_write;
  logic              drive;
  logic [HALF_W-1:0] dq_out;
  logic [HALF_W-1:0] wdata_hi;
  logic [31:0]       read_data_q;
  logic [WORD_W-1:0] word_sel;
  logic              req;
  logic              last;

  assign req      = mem.rd_en | mem.wr_en;
  assign word_sel = WORD_W'((mem.address - 32'(BASE_ADDR)) >> 2);

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state == IDLE) && req),
    .enable ((state == LO) || (state == HI)),
    .last   (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      drive       <= 1'b0;
      dq_out      <= '0;
      wdata_hi    <= '0;
      read_data_q <= '0;
      SRAM_ADDR   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // A simultaneous rd_en/wr_en resolves to a read.
            state     <= LO;
            is_write  <= mem.wr_en & ~mem.rd_en;
            drive     <= mem.wr_en & ~mem.rd_en;
            dq_out    <= mem.write_data[HALF_W-1:0];
            wdata_hi  <= mem.write_data[31:HALF_W];
            SRAM_ADDR <= {word_sel, 1'b0};
          end
        end
        LO: begin
          if (last) begin
            if (!is_write) read_data_q[HALF_W-1:0] <= SRAM_DQ;
            state        <= HI;
            dq_out       <= wdata_hi;
            SRAM_ADDR[0] <= 1'b1;
          end
        end
        HI: begin
          if (last) begin
            if (!is_write) read_data_q[31:HALF_W] <= SRAM_DQ;
            state <= DONE;
            drive <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Last cycle of each write phase keeps address/data stable with WE_N high.
  assign SRAM_WE_N = ~(drive & (ONE_CYCLE | ~last));
  assign SRAM_DQ   = drive ? dq_out : {HALF_W{1'bz}};

  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign mem.read_data = read_data_q;
  assign mem.ready     = ((state == IDLE) && !req) || (state == DONE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed table, reset abort, and random
// accesses against a word-level reference memory and an SRAM model.
module tb_sram_controller;
  import arm_mem_pkg::*;

  localparam int unsigned W    = 5;
  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;

  logic clk;
  logic rst;

  sram_controller_if mem_bus ();

  wire  [15:0]   sram_dq;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n;
  logic          sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;
  mem_state_t    dbg_state;

  sram_controller #(
    .WAIT_CYCLES (W),
    .BASE_ADDR   (BASE),
    .SRAM_AW     (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (mem_bus),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_OE_N (sram_oe_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // undriven bus reads as all ones
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (sram_dq[g]);
  end

  // SRAM model: captures while WE_N low, drives only for bench-issued reads
  logic [15:0] sram_mem [0:63];
  logic        model_rd;
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr[5:0]] <= sram_dq;
  assign sram_dq = (model_rd && sram_we_n) ? sram_mem[sram_addr[5:0]] : 16'hzzzz;

  // reference model (word granularity)
  logic [31:0] ref_mem [0:7];
  logic [31:0] last_read;

  int n_vec;
  int n_miss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    mem_bus.rd_en      = 1'b0;
    mem_bus.wr_en      = 1'b0;
    mem_bus.address    = '0;
    mem_bus.write_data = '0;
    model_rd           = 1'b0;
  endtask

  // One full access; per-cycle bus expectations derived from the phase rules.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata);
    int          word;
    logic        is_wr;
    int          k;
    logic [31:0] exp_addr;
    logic        exp_we_n;
    word  = int'((addr - BASE) >> 2);
    is_wr = wr && !rd;
    @(negedge clk);
    mem_bus.rd_en      = rd;
    mem_bus.wr_en      = wr;
    mem_bus.address    = addr;
    mem_bus.write_data = wdata;
    model_rd           = !is_wr;
    #1;
    check("ready_c0", 32'(mem_bus.ready), 32'd0);
    for (int i = 1; i <= 2 * W; i++) begin
      @(negedge clk);
      k        = (i - 1) % W;
      exp_addr = 32'(word * 2 + ((i > W) ? 1 : 0));
      exp_we_n = !(is_wr && (W == 1 || k < W - 1));
      check("ready_busy", 32'(mem_bus.ready), 32'd0);
      check("sram_addr", 32'(sram_addr), exp_addr);
      check("we_n", 32'(sram_we_n), 32'(exp_we_n));
      if (is_wr)
        check("dq_write", 32'(sram_dq), (i > W) ? 32'(wdata[31:16]) : 32'(wdata[15:0]));
    end
    @(negedge clk);
    check("ready_done", 32'(mem_bus.ready), 32'd1);
    check("read_data", mem_bus.read_data, exp_rdata);
    // request stays up through DONE, dropped just after the retiring edge
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    check("ready_after", 32'(mem_bus.ready), 32'd1);
    check("we_n_after", 32'(sram_we_n), 32'd1);
    check("dq_z_after", 32'(sram_dq), 32'hFFFF);
    check("state_after", 32'(dbg_state), 32'(IDLE));
    if (is_wr) ref_mem[word] = wdata;
    else       last_read = ref_mem[word];
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    for (int i = 0; i < 64; i++) sram_mem[i] = 16'h0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;
    last_read = 32'h0;
    idle_inputs();

    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 32'h00000000};
    vecs[3] = '{1'b0, 1'b1, 32'd1029, 32'hCAFEF00D, 32'h00000000};
    vecs[4] = '{1'b1, 1'b0, 32'd1030, 32'h0,        32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 32'd1027, 32'h0,        32'hDEADBEEF};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(mem_bus.ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_dq_z", 32'(sram_dq), 32'hFFFF);
    check("rst_read_data", mem_bus.read_data, 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("tie_offs", {28'h0, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'h0);

    foreach (vecs[v]) begin
      do_access(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);
      if (v == 0) begin
        check("sram_mem0", 32'(sram_mem[0]), 32'hBEEF);
        check("sram_mem1", 32'(sram_mem[1]), 32'hDEAD);
      end
      if (v == 2) begin
        check("rdwr_no_write_lo", 32'(sram_mem[2]), 32'h0);
        check("rdwr_no_write_hi", 32'(sram_mem[3]), 32'h0);
      end
    end

    // Reset during the first HI cycle of a write: low half already stored.
    @(negedge clk);
    mem_bus.wr_en      = 1'b1;
    mem_bus.address    = 32'd1028;
    mem_bus.write_data = 32'hA5A55A5A;
    repeat (W + 1) @(negedge clk);
    check("abort_pre_we_n", 32'(sram_we_n), 32'd0);
    check("abort_pre_dq", 32'(sram_dq), 32'hA5A5);
    rst = 1'b1;
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_dq_z", 32'(sram_dq), 32'hFFFF);
    check("abort_read_data", mem_bus.read_data, 32'h0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    ref_mem[1] = {ref_mem[1][31:16], 16'h5A5A};
    last_read  = 32'h0;
    @(negedge clk);
    check("abort_ready", 32'(mem_bus.ready), 32'd1);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, ref_mem[1]);

    // Random accesses over the first eight words.
    for (int n = 0; n < 40; n++) begin
      logic        rd, wr;
      logic [31:0] addr, wdata;
      int          word;
      int          op;
      op    = int'($urandom_range(0, 4));
      rd    = (op == 0 || op == 1 || op == 4);
      wr    = (op == 2 || op == 3 || op == 4);
      word  = int'($urandom_range(0, 7));
      addr  = BASE + 32'(word) * 4 + 32'($urandom_range(0, 3));
      wdata = $urandom;
      do_access(rd, wr, addr, wdata, rd ? ref_mem[word] : last_read);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-side responder for the MEM stage's load/store requests.
- Accepts one 32-bit word read or write per request and performs it on an external 16-bit asynchronous SRAM as two half-word phases (low, then high).
- Holds `ready` low until the access completes. The pipeline freezes all stage registers while a request is pending and `ready`=0.

Parameters:
- WAIT_CYCLES, 5, cycles per half-word phase (minimum 1).
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rd_en  input  1  load request from MEM stage
- wr_en  input  1  store request from MEM stage
- address  input  32  byte address (ALU result)
- write_data  input  32  store data (val_Rm)
- read_data  output  32  load result
- ready  output  1  1 = no access pending / access completing this cycle
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  output  SRAM_AW  SRAM half-word address
- SRAM_WE_N  output  1  write enable, active low
- SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  tied 0

Behaviour:

Clock and reset:
- Single clock domain; rst is asynchronous and active-high.
- Reset values: state=IDLE, read_data=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=Z, counter=0.
- Reset mid-access aborts immediately. WE_N returns to 1 and DQ goes to Z without waiting for a clock. No partial completion is reported.

Address and data mapping:
- word = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
- Low half is at {word,0}; high half is at {word,1}.
- address[1:0] is ignored.

States (`IDLE`, `LO`, `HI`, `DONE`):
- IDLE: if rd_en|wr_en, latch the op, word and write_data, clear the counter, and go to LO.
  - If rd_en and wr_en are both 1, perform a read; WE_N stays 1.
- LO: SRAM_ADDR={word,0}.
  - Write: DQ=wdata[15:0].
  - Read: DQ=Z; read_data[15:0] is sampled at the edge ending the last phase cycle.
  - The counter runs 0..WAIT_CYCLES-1, then the state goes to HI with the counter cleared.
- HI: same as LO using {word,1} and bits [31:16].
- DONE: held one cycle, then IDLE.

Write strobe:
- SRAM_WE_N=0 during write phases for counter < WAIT_CYCLES-1, giving one cycle of address/data hold with WE_N=1.
- If WAIT_CYCLES=1, WE_N=0 for the whole phase.
- DQ is driven only during write phases and is Z otherwise.

ready (combinational):
- ready = (IDLE & ~(rd_en|wr_en)) | DONE.
- A request presented in IDLE in cycle 0 sees ready=1 in cycle 2*WAIT_CYCLES+1; the pipeline advances at that edge.
- The request still asserted during DONE is not re-accepted, because DONE always returns to IDLE. Exactly one access occurs per request.

read_data:
- Updated only by reads and holds until the next completed read; writes never alter it.
- Both halves are valid when ready rises in DONE.

Inputs are ignored outside IDLE because all operands are latched at acceptance.

Decomposition:
- Shared package `arm_mem_pkg`:
  - state enum (IDLE/LO/HI/DONE, 2-bit);
  - BASE_ADDR default;
  - SRAM_AW;
  - half-word width constant.
- One sub-module, `sram_wait_counter`, with inputs clk, rst, clear, enable and output last (= count==WAIT_CYCLES-1).
- The FSM, address mapping and tristate logic stay in sram_controller.

Test Plan:
- Reset with no requests -> ready=1, SRAM_WE_N=1, SRAM_DQ=Z, read_data=0.
- Write address=1024, data=0xDEADBEEF, WAIT_CYCLES=5:
  - cycles 1-5: ADDR=0, DQ=0xBEEF, WE_N low cycles 1-4;
  - cycles 6-10: ADDR=1, DQ=0xDEAD;
  - ready=1 in cycle 11 only; the SRAM model holds [0]=0xBEEF, [1]=0xDEAD.
- Read address=1024 after the write -> DQ=Z throughout, WE_N=1, read_data=0xDEADBEEF when ready rises in cycle 11.
- Write 0x12345678 to address 1028 with rd_en=wr_en=1 -> read performed (WE_N never 0), ADDR sequence 2 then 3.
- Request held high through DONE, then dropped -> exactly one LO/HI sequence; ready=1 afterwards.
- Assert rst during HI of a write -> WE_N=1 and DQ=Z immediately, read_data=0. A subsequent read of 1028 completes normally in 11 cycles.
